// File: rtl/param_ring_counter_if.sv
// Control and status bundle for param_ring_counter.
// The master side issues step/load controls; the slave side returns the
// counter state together with its wrap and error pulses.
interface param_ring_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  count, tc, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output count, tc, err
  );
endinterface

// File: rtl/param_ring_counter.sv
// Parametrised ring / Johnson counter with enable, direction, parallel load,
// illegal-state self-correction and a one-cycle wrap pulse.
// The seed state tracks the mode input of the current cycle:
// ring seeds to a single LSB, Johnson seeds to all zeros.
module param_ring_counter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 init,
  param_ring_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;
  logic             err_d, err_q;
  logic [WIDTH-1:0] seed_s;
  logic [WIDTH-1:0] step_s;
  logic             load_ok_s;
  logic             count_ok_s;

  // A ring state is legal when exactly one bit is set.
  function automatic logic ring_legal(input logic [WIDTH-1:0] x);
    int n;
    n = 32'sd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        n = n + 32'sd1;
      end else begin
        n = n;
      end
    end
    return (n == 32'sd1);
  endfunction

  // A Johnson state is legal when it has at most one boundary between
  // adjacent bits (a single run of ones against a single run of zeros).
  function automatic logic johnson_legal(input logic [WIDTH-1:0] x);
    int n;
    n = 32'sd0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (x[i] != x[i+1]) begin
        n = n + 32'sd1;
      end else begin
        n = n;
      end
    end
    return (n <= 32'sd1);
  endfunction

  // Seed, one-step successor and legality of the current and load values.
  always_comb begin
    seed_s = bus.mode ? {WIDTH{1'b0}} : {{(WIDTH-1){1'b0}}, 1'b1};
    step_s = count_q;
    case ({bus.mode, bus.dir})
      2'b00:   step_s = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      2'b01:   step_s = {count_q[0], count_q[WIDTH-1:1]};
      2'b10:   step_s = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      2'b11:   step_s = {~count_q[0], count_q[WIDTH-1:1]};
      default: step_s = count_q;
    endcase
    load_ok_s  = bus.mode ? johnson_legal(bus.load_val) : ring_legal(bus.load_val);
    count_ok_s = bus.mode ? johnson_legal(count_q)      : ring_legal(count_q);
  end

  // Next-state priority below init: load, correction, step, hold.
  // Correction is deliberately not gated by en so upsets and mode switches
  // are repaired even while the counter is paused.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok_s) begin
        count_d = bus.load_val;
      end else begin
        count_d = seed_s;
        err_d   = 1'b1;
      end
    end else if (!count_ok_s) begin
      count_d = seed_s;
      err_d   = 1'b1;
    end else if (bus.en) begin
      count_d = step_s;
      tc_d    = (step_s == seed_s);
    end else begin
      count_d = count_q;
    end
  end

  // State and pulse registers; init forces the seed and clears both pulses.
  always_ff @(posedge clk) begin
    if (init) begin
      count_q <= seed_s;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_param_ring_counter.sv
// Bench for param_ring_counter (WIDTH=8). Each scenario builds a stimulus
// table; applying a vector pushes its expected outputs to a scoreboard, and
// the scenario pops and compares once the DUT has produced that cycle's state.
module tb_param_ring_counter;

  typedef struct packed {
    logic       init;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [7:0] val;
    logic [7:0] ecnt;
    logic       etc;
    logic       eerr;
  } vec_t;

  logic clk = 1'b0;
  logic init;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] sb_q[$];

  param_ring_counter_if #(.WIDTH(8)) bif ();

  param_ring_counter #(.WIDTH(8)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i_init, input logic i_en, input logic i_dir,
                              input logic i_mode, input logic i_load, input logic [7:0] i_val,
                              input logic [7:0] e_cnt, input logic e_tc, input logic e_err);
    vec_t v;
    v.init = i_init; v.en = i_en; v.dir = i_dir; v.mode = i_mode; v.load = i_load;
    v.val = i_val; v.ecnt = e_cnt; v.etc = e_tc; v.eerr = e_err;
    return v;
  endfunction

  // Ring value after k left steps from 01.
  function automatic logic [7:0] ring_exp(input int k);
    logic [7:0] r;
    r = 8'h01 << (k % 8);
    return r;
  endfunction

  // Johnson value after k left steps from 00: k ones filling from the LSB,
  // then zeros filling from the LSB.
  function automatic logic [7:0] johnson_exp(input int k);
    logic [8:0] t9;
    logic [7:0] t8;
    if (k <= 8) begin
      t9 = (9'h001 << k) - 9'h001;
      return t9[7:0];
    end else begin
      t8 = 8'hFF << (k - 8);
      return t8;
    end
  endfunction

  // Drive one vector, record its expected outputs, advance past the edge.
  task automatic apply(input vec_t v);
    init         = v.init;
    bif.en       = v.en;
    bif.dir      = v.dir;
    bif.mode     = v.mode;
    bif.load     = v.load;
    bif.load_val = v.val;
    sb_q.push_back({v.ecnt, v.etc, v.eerr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_ring_wrap();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    for (int k = 1; k <= 9; k++)
      v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ring_exp(k), (k == 8), 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL ring_wrap[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_johnson_wrap();
    vec_t v[$];
    logic [9:0] exp;
    logic [7:0] fwd, rev;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    for (int k = 1; k <= 16; k++)
      v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, johnson_exp(k), (k == 16), 1'b0));
    // Right-going Johnson is the bit-mirror of the left-going sequence.
    for (int k = 1; k <= 16; k++) begin
      fwd = johnson_exp(k);
      rev = {<<{fwd}};
      v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, rev, (k == 16), 1'b0));
    end
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL johnson_wrap[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reverse_hold();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0));
    for (int k = 6; k >= 0; k--)
      v.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, ring_exp(k), (k == 0), 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL reverse_hold[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_load();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h01, 1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL load[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_mode_switch();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL mode_switch[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_priority();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h20, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 8'h04, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL priority[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [9:0] exp;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h01, 1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({bif.count, bif.tc, bif.err} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, bif.count, bif.tc, bif.err, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    init         = 1'b1;
    bif.en       = 1'b0;
    bif.dir      = 1'b0;
    bif.mode     = 1'b0;
    bif.load     = 1'b0;
    bif.load_val = 8'h00;
    test_reset();
    test_ring_wrap();
    test_johnson_wrap();
    test_reverse_hold();
    test_load();
    test_mode_switch();
    test_priority();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
